// File: rtl/draw_pkg.sv
// draw_pkg: shared constants and types for the statistic number renderer.
//   FONT_W / FONT_H     glyph cell size in pixels
//   GLYPH_BLANK         font code of the empty glyph
//   GLYPH_DIGIT_BASE    font code of digit '0'; digit d uses code d + base
//   fsm_state_t         conversion controller states
//   pow10()             elaboration-time power of ten for the saturation limit
package draw_pkg;

    localparam int unsigned FONT_W = 8;
    localparam int unsigned FONT_H = 16;

    localparam logic [3:0] GLYPH_BLANK      = 4'd0;
    localparam logic [3:0] GLYPH_DIGIT_BASE = 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } fsm_state_t;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary to BCD converter.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load value, clear the BCD scratch and begin converting
//   value       binary input, sampled on start
//   bcd         NUM_DIGITS packed BCD nibbles, final after the done cycle
//   done        high during the last of the VALUE_W shift cycles
module bin2bcd_seq #(
    parameter int unsigned VALUE_W    = 16,
    parameter int unsigned NUM_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      value,
    output logic [NUM_DIGITS*4-1:0] bcd,
    output logic                    done
);

    localparam int unsigned BCD_W = NUM_DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

    logic [VALUE_W-1:0] shreg;
    logic [CNT_W-1:0]   cnt;
    logic               active;
    logic [BCD_W-1:0]   adj;

    // Add-3 correction on every nibble >= 5 ahead of the shift.
    always_comb begin
        adj = bcd;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign done = active && (cnt == CNT_W'(VALUE_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bcd    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            shreg  <= value;
            bcd    <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            bcd   <= {adj[BCD_W-2:0], shreg[VALUE_W-1]};
            shreg <= {shreg[VALUE_W-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stat_number_draw.sv
// stat_number_draw: renders one unsigned statistic as a fixed-width decimal
// field at (X0, Y0) using a downstream 256x8 font ROM.
//   Clk, Reset_n  pixel clock, asynchronous active-low reset
//   value_in      binary value to display
//   load          one-cycle request to convert value_in
//   busy          conversion in progress or a request pending
//   DrawX, DrawY  current pixel position
//   font_addr     registered ROM address {glyph_code, row}
//   font_data     ROM data (combinational), bit 7 = leftmost pixel
//   pixel_on      foreground flag for the position sampled two cycles earlier
module stat_number_draw
    import draw_pkg::*;
#(
    parameter int unsigned VALUE_W    = 16,
    parameter int unsigned NUM_DIGITS = 5,
    parameter logic [9:0]  X0         = 10'd0,
    parameter logic [9:0]  Y0         = 10'd0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               load,
    output logic               busy,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [7:0]         font_addr,
    input  logic [7:0]         font_data,
    output logic               pixel_on
);

    localparam logic [63:0] SAT_LIMIT = pow10(NUM_DIGITS);
    localparam logic [11:0] X_LO = 12'(X0);
    localparam logic [11:0] X_HI = 12'(X0) + 12'(FONT_W * NUM_DIGITS);
    localparam logic [11:0] Y_LO = 12'(Y0);
    localparam logic [11:0] Y_HI = 12'(Y0) + 12'(FONT_H);

    fsm_state_t state, state_next;

    logic                    start;
    logic                    start_from_pending;
    logic [VALUE_W-1:0]      start_val;
    logic                    pending;
    logic [VALUE_W-1:0]      pending_val;
    logic                    sat_q;
    logic [NUM_DIGITS*4-1:0] eng_bcd;
    logic                    eng_done;
    logic [3:0]              disp [NUM_DIGITS];
    logic [3:0]              commit_codes [NUM_DIGITS];
    logic                    leading;
    logic [3:0]              nib;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (Clk),
        .rst_n (Reset_n),
        .start (start),
        .value (start_val),
        .bcd   (eng_bcd),
        .done  (eng_done)
    );

    // ---------------- conversion controller ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request that lands in COMMIT without a pending one is parked in
    // pending, so IDLE also has to start from pending.
    always_comb begin
        state_next         = state;
        start              = 1'b0;
        start_from_pending = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    start              = 1'b1;
                    start_from_pending = 1'b1;
                    state_next         = CONVERT;
                end else if (load) begin
                    start      = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (eng_done) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (pending) begin
                    start              = 1'b1;
                    start_from_pending = 1'b1;
                    state_next         = CONVERT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign start_val = start_from_pending ? pending_val : value_in;
    assign busy      = (state != IDLE) || pending;

    // Last load wins; a load coinciding with a pending restart refills pending.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending     <= 1'b0;
            pending_val <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (start_from_pending) begin
                pending <= load;
                if (load) begin
                    pending_val <= value_in;
                end
            end else if (load && busy) begin
                pending     <= 1'b1;
                pending_val <= value_in;
            end
            if (start) begin
                sat_q <= (64'(start_val) >= SAT_LIMIT);
            end
        end
    end

    // ---------------- commit: saturation and leading-zero blanking ----------------
    always_comb begin
        leading = 1'b1;
        nib     = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            nib = sat_q ? 4'd9 : eng_bcd[(NUM_DIGITS-1-i)*4 +: 4];
            if (leading && (nib == 4'd0) && (i != NUM_DIGITS - 1)) begin
                commit_codes[i] = GLYPH_BLANK;
            end else begin
                commit_codes[i] = nib + GLYPH_DIGIT_BASE;
                leading         = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                disp[i] <= (i == NUM_DIGITS - 1) ? GLYPH_DIGIT_BASE : GLYPH_BLANK;
            end
        end else if (state == COMMIT) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                disp[i] <= commit_codes[i];
            end
        end
    end

    // ---------------- pixel pipeline ----------------
    logic       in_box;
    logic [9:0] dx;
    logic [3:0] row;
    logic [3:0] code;
    logic [2:0] col_q;
    logic       in_box_q;

    // Bounds compared at 12 bits so fields near the right/bottom edge do not wrap.
    assign in_box = (12'(DrawX) >= X_LO) && (12'(DrawX) < X_HI) &&
                    (12'(DrawY) >= Y_LO) && (12'(DrawY) < Y_HI);
    assign dx     = DrawX - X0;
    assign row    = 4'(DrawY - Y0);

    always_comb begin
        code = GLYPH_BLANK;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (in_box && (dx[9:3] == 7'(i))) begin
                code = disp[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            font_addr <= 8'h00;
            col_q     <= '0;
            in_box_q  <= 1'b0;
            pixel_on  <= 1'b0;
        end else begin
            font_addr <= in_box ? {code, row} : 8'h00;
            col_q     <= dx[2:0];
            in_box_q  <= in_box;
            pixel_on  <= in_box_q & font_data[3'd7 - col_q];
        end
    end

endmodule

// File: tb/tb_stat_number_draw.sv
// tb_stat_number_draw: directed self-checking bench for stat_number_draw.
// Pixel expectations are queued when DrawX/DrawY are driven and compared when
// the pipeline delivers them; a second, 3-digit instance covers saturation.
module tb_stat_number_draw;

    localparam int unsigned ND  = 5;
    localparam logic [9:0]  BX0 = 10'd100;
    localparam logic [9:0]  BY0 = 10'd50;
    localparam logic [9:0]  SX0 = 10'd300;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;
    logic        busy;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [7:0]  font_addr;
    logic [7:0]  font_data;
    logic        pixel_on;

    logic [15:0] s_value = '0;
    logic        s_load = 1'b0;
    logic        s_busy;
    logic [7:0]  s_font_addr;
    logic [7:0]  s_font_data;
    logic        s_pixel_on;

    int checks = 0;
    int errors = 0;
    int unsigned edge_cnt = 0;

    typedef struct {
        int unsigned due;
        logic [7:0]  v;
        string       tag;
    } exp_t;

    exp_t fa_q[$];
    exp_t px_q[$];
    logic [3:0] exp_disp [ND];

    always #5 Clk = ~Clk;

    // Font ROM stand-in: blank glyph is empty, glyph '0' row 2 is 0x7C.
    function automatic logic [7:0] rom(input logic [7:0] a);
        if (a[7:4] == 4'd0) return 8'h00;
        if (a == 8'h12) return 8'h7C;
        return (a * 8'd37) ^ 8'h5A;
    endfunction

    assign font_data   = rom(font_addr);
    assign s_font_data = rom(s_font_addr);

    stat_number_draw #(
        .VALUE_W    (16),
        .NUM_DIGITS (ND),
        .X0         (BX0),
        .Y0         (BY0)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .value_in  (value_in),
        .load      (load),
        .busy      (busy),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .font_addr (font_addr),
        .font_data (font_data),
        .pixel_on  (pixel_on)
    );

    stat_number_draw #(
        .VALUE_W    (16),
        .NUM_DIGITS (3),
        .X0         (SX0),
        .Y0         (BY0)
    ) dut_sat (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .value_in  (s_value),
        .load      (s_load),
        .busy      (s_busy),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .font_addr (s_font_addr),
        .font_data (s_font_data),
        .pixel_on  (s_pixel_on)
    );

    // Scoreboard consumer: compares queued expectations 1 ns after their edge.
    always @(posedge Clk) begin : sb
        exp_t e;
        edge_cnt++;
        #1;
        while (fa_q.size() > 0 && fa_q[0].due == edge_cnt) begin
            e = fa_q.pop_front();
            checks++;
            assert (font_addr === e.v) else begin
                errors++;
                $error("FAIL %s font_addr got %h want %h", e.tag, font_addr, e.v);
            end
        end
        while (px_q.size() > 0 && px_q[0].due == edge_cnt) begin
            e = px_q.pop_front();
            checks++;
            assert (pixel_on === e.v[0]) else begin
                errors++;
                $error("FAIL %s pixel_on got %b want %b", e.tag, pixel_on, e.v[0]);
            end
        end
    end

    // Expected display codes for value v on the 5-digit field.
    task automatic set_model(input int unsigned v);
        int unsigned d [ND];
        int unsigned t;
        bit          lead;
        t = v;
        for (int i = ND - 1; i >= 0; i--) begin
            d[i] = t % 10;
            t    = t / 10;
        end
        lead = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (v >= 100000) begin
                exp_disp[i] = 4'd10;
            end else if (lead && d[i] == 0 && i != ND - 1) begin
                exp_disp[i] = 4'd0;
            end else begin
                exp_disp[i] = 4'(d[i] + 1);
                lead        = 1'b0;
            end
        end
    endtask

    // Drive one pixel position for one cycle and queue its expected outputs.
    task automatic pix(input logic [9:0] x, input logic [9:0] y, input string tag);
        exp_t       e;
        logic [7:0] a;
        logic [7:0] r;
        logic [9:0] dx;
        logic       inb;
        logic       bitv;
        DrawX = x;
        DrawY = y;
        inb = (x >= BX0) && ({1'b0, x} < ({1'b0, BX0} + 11'd40)) &&
              (y >= BY0) && ({1'b0, y} < ({1'b0, BY0} + 11'd16));
        dx   = x - BX0;
        a    = 8'h00;
        bitv = 1'b0;
        if (inb) begin
            a    = {exp_disp[dx / 8], 4'(y - BY0)};
            r    = rom(a);
            bitv = r[7 - dx[2:0]];
        end
        e.due = edge_cnt + 1; e.v = a;              e.tag = tag; fa_q.push_back(e);
        e.due = edge_cnt + 2; e.v = {7'b0, bitv};   e.tag = tag; px_q.push_back(e);
        @(negedge Clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        @(negedge Clk);
        load = 1'b0;
    endtask

    // Counts negedges with busy high; bounded so a stuck busy still ends.
    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge Clk);
        end
        checks++;
        assert (busy === 1'b0) else begin
            errors++;
            $error("FAIL %s busy timeout got %b want 0", tag, busy);
        end
    endtask

    task automatic row_digits(input logic [9:0] row, input string tag);
        for (int i = 0; i < ND; i++) begin
            pix(BX0 + 10'(8 * i + 3), BY0 + row, tag);
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic sat_check(input logic [15:0] v, input logic [9:0] x,
                             input logic [7:0] want, input string tag);
        int   n;
        logic [7:0] r;
        s_load  = 1'b1;
        s_value = v;
        @(negedge Clk);
        s_load = 1'b0;
        n = 0;
        while (s_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge Clk);
        end
        checks++;
        assert (s_busy === 1'b0) else begin
            errors++;
            $error("FAIL %s s_busy timeout got %b want 0", tag, s_busy);
        end
        DrawX = x;
        DrawY = BY0 + 10'd3;
        @(posedge Clk); #1;
        checks++;
        assert (s_font_addr === want) else begin
            errors++;
            $error("FAIL %s s_font_addr got %h want %h", tag, s_font_addr, want);
        end
        r = rom(want);
        @(posedge Clk); #1;
        checks++;
        assert (s_pixel_on === r[7 - 3'(x - SX0)]) else begin
            errors++;
            $error("FAIL %s s_pixel_on got %b want %b", tag, s_pixel_on, r[7 - 3'(x - SX0)]);
        end
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  bok;

        // Reset state
        repeat (2) @(negedge Clk);
        checks++;
        assert (busy === 1'b0 && font_addr === 8'h00 && pixel_on === 1'b0) else begin
            errors++;
            $error("FAIL reset_outs got %b/%h/%b want 0/00/0", busy, font_addr, pixel_on);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        set_model(0);

        // Reset display: "0" in the units digit, blanks elsewhere
        pix(BX0 + 10'd33, BY0 + 10'd2, "rst_d4c1");
        pix(BX0 + 10'd32, BY0 + 10'd2, "rst_d4c0");
        pix(BX0 + 10'd0,  BY0 + 10'd2, "rst_d0c0");
        pix(BX0 + 10'd1,  BY0 + 10'd9, "rst_d0blank");
        repeat (2) @(negedge Clk);

        // 1234: busy length and digits
        do_load(16'd1234);
        wait_idle("busy_1234", n);
        checks++;
        assert (n == 17) else begin
            errors++;
            $error("FAIL busy_len got %0d want 17", n);
        end
        set_model(1234);
        row_digits(10'd5, "v1234");

        // 0 after 1234
        do_load(16'd0);
        wait_idle("busy_0", n);
        set_model(0);
        row_digits(10'd5, "v0");

        // 500, then 42 at +3, then 7 at +5: busy continuous, 500 then 7
        load     = 1'b1;
        value_in = 16'd500;
        @(negedge Clk);
        bok = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            load = (k == 3 || k == 5);
            if (k == 3) value_in = 16'd42;
            if (k == 5) value_in = 16'd7;
            if (busy !== 1'b1) bok = 1'b0;
            @(negedge Clk);
        end
        load = 1'b0;
        checks++;
        assert (bok === 1'b1) else begin
            errors++;
            $error("FAIL busy_continuous got %b want 1", bok);
        end
        set_model(500);
        row_digits(10'd5, "v500");
        wait_idle("busy_7", n);
        set_model(7);
        row_digits(10'd7, "v7");

        // Asynchronous reset during a conversion of 999
        DrawX = BX0 + 10'd35;
        DrawY = BY0 + 10'd2;
        do_load(16'd999);
        repeat (7) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checks++;
        assert (busy === 1'b0 && pixel_on === 1'b0 && font_addr === 8'h00) else begin
            errors++;
            $error("FAIL async_rst got %b/%b/%h want 0/0/00", busy, pixel_on, font_addr);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        set_model(0);
        row_digits(10'd4, "post_rst");
        do_load(16'd999);
        wait_idle("busy_999", n);
        checks++;
        assert (n == 17) else begin
            errors++;
            $error("FAIL busy_len_999 got %0d want 17", n);
        end
        set_model(999);
        row_digits(10'd5, "v999");

        // Field boundaries and a full row sweep
        pix(BX0 - 10'd1,  BY0 + 10'd3,  "left_out");
        pix(BX0 + 10'd40, BY0 + 10'd3,  "right_out");
        pix(BX0 + 10'd39, BY0 + 10'd16, "below_out");
        pix(BX0 + 10'd39, BY0 + 10'd15, "last_in");
        pix(BX0 + 10'd20, BY0 - 10'd1,  "above_out");
        for (int x = -2; x <= 41; x++) begin
            pix(10'(int'(BX0) + x), BY0 + 10'd6, "sweep");
        end
        repeat (2) @(negedge Clk);

        // Saturation on the 3-digit field: 1000 -> "999", 998 -> "998"
        sat_check(16'd1000, SX0 + 10'd17, 8'hA3, "sat_1000_d2");
        sat_check(16'd998,  SX0 + 10'd17, 8'h93, "sat_998_d2");
        sat_check(16'd998,  SX0 + 10'd1,  8'hA3, "sat_998_d0");

        repeat (3) @(negedge Clk);
        checks++;
        assert (fa_q.size() == 0 && px_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain got %0d/%0d want 0/0", fa_q.size(), px_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
